// File: rtl/deframing_if.sv
// Serial-in / byte-out bundle between the serializer output and the byte consumer.
// The slave side is the deframer; the master side feeds bits and takes bytes.
interface deframing_if;
    logic       din;
    logic       din_valid;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_start;
    logic       frame_end;
    logic [7:0] frame_len;
    logic       frame_error;
    logic       sync_error;

    modport master (
        output din, din_valid,
        input  dout, dout_valid, frame_start, frame_end, frame_len, frame_error, sync_error
    );

    modport slave (
        input  din, din_valid,
        output dout, dout_valid, frame_start, frame_end, frame_len, frame_error, sync_error
    );
endinterface

// File: rtl/deframing.sv
// Reassembles LSB-first serial bursts into bytes, checks the sync header and
// reports payload bytes, frame boundaries, frame length and error pulses.
module deframing #(
    parameter logic [7:0]  SYNC_BYTE = 8'h7E,
    parameter int unsigned MAX_LEN   = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    deframing_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DISCARD} state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state, state_d;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] len_cnt;

    logic [7:0] dout_q, dout_d;
    logic [7:0] frame_len_q, frame_len_d;
    logic       dout_valid_q, dout_valid_d;
    logic       frame_start_q, frame_start_d;
    logic       frame_end_q, frame_end_d;
    logic       frame_error_q, frame_error_d;
    logic       sync_error_q, sync_error_d;

    logic       byte_done;
    logic [7:0] byte_w;
    logic       len_full;

    // byte_w is the complete byte as it will stand once the current bit lands
    assign byte_done = bus.din_valid && (bit_cnt == 3'd7);
    assign byte_w    = {bus.din, shreg[7:1]};
    assign len_full  = (len_cnt == MAX_LEN_B);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (bus.din_valid) state_d = HEADER;
            HEADER: begin
                if (!bus.din_valid)  state_d = IDLE;
                else if (byte_done)  state_d = (byte_w == SYNC_BYTE) ? PAYLOAD : DISCARD;
            end
            PAYLOAD: begin
                if (!bus.din_valid)             state_d = IDLE;
                else if (byte_done && len_full) state_d = DISCARD;
            end
            DISCARD: if (!bus.din_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d        = dout_q;
        frame_len_d   = frame_len_q;
        dout_valid_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        frame_error_d = 1'b0;
        sync_error_d  = 1'b0;
        unique case (state)
            HEADER: begin
                if (!bus.din_valid)                       frame_error_d = 1'b1;
                else if (byte_done && byte_w != SYNC_BYTE) sync_error_d = 1'b1;
            end
            PAYLOAD: begin
                if (!bus.din_valid) begin
                    // a partial byte at the end of the burst is dropped, not delivered
                    if (bit_cnt == 3'd0) begin
                        frame_end_d = 1'b1;
                        frame_len_d = len_cnt;
                    end else begin
                        frame_error_d = 1'b1;
                    end
                end else if (byte_done) begin
                    if (len_full) begin
                        frame_error_d = 1'b1;
                    end else begin
                        dout_valid_d  = 1'b1;
                        dout_d        = byte_w;
                        frame_start_d = (len_cnt == 8'd0);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt       <= '0;
            shreg         <= '0;
            len_cnt       <= '0;
            dout_q        <= '0;
            frame_len_q   <= '0;
            dout_valid_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_error_q <= 1'b0;
            sync_error_q  <= 1'b0;
        end else begin
            // every din_valid=0 cycle lands in IDLE, so counters clear here
            if (!bus.din_valid) begin
                bit_cnt <= '0;
                len_cnt <= '0;
            end else if (state != DISCARD) begin
                shreg   <= byte_w;
                bit_cnt <= bit_cnt + 3'd1;
                if (state == PAYLOAD && byte_done && !len_full) len_cnt <= len_cnt + 8'd1;
            end
            dout_q        <= dout_d;
            frame_len_q   <= frame_len_d;
            dout_valid_q  <= dout_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            frame_error_q <= frame_error_d;
            sync_error_q  <= sync_error_d;
        end
    end

    assign bus.dout        = dout_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.dout_valid  = dout_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.frame_error = frame_error_q;
    assign bus.sync_error  = sync_error_q;
endmodule

// File: tb/tb_deframing.sv
// Directed bench for deframing: a frame-level vector table plus cycle-exact
// sequences for latency, back-to-back bursts and mid-frame reset.
module tb_deframing;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic din = 1'b0;
    logic din_valid = 1'b0;

    always #5 clk = ~clk;

    deframing_if bus();
    deframing_if bus2();
    assign bus.din        = din;
    assign bus.din_valid  = din_valid;
    assign bus2.din       = din;
    assign bus2.din_valid = din_valid;

    deframing #(.SYNC_BYTE(8'h7E), .MAX_LEN(255)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
    deframing #(.SYNC_BYTE(8'h7E), .MAX_LEN(2))   dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    typedef struct {
        string       name;
        int          sel;        // 0: MAX_LEN=255 instance, 1: MAX_LEN=2 instance
        logic [31:0] bits;       // stream, bit i is sent on cycle i
        int          nbits;
        int          exp_nout;
        logic [23:0] exp_bytes;  // first payload byte in [7:0]
        int          exp_start;
        int          exp_end;
        logic [7:0]  exp_len;
        int          exp_ferr;
        int          exp_serr;
    } vec_t;

    int checks = 0;
    int errors = 0;

    int          n_out[2], n_start[2], n_end[2], n_ferr[2], n_serr[2];
    logic [23:0] obs_b[2];
    logic [7:0]  last_len[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        for (int d = 0; d < 2; d++) begin
            n_out[d] = 0; n_start[d] = 0; n_end[d] = 0; n_ferr[d] = 0; n_serr[d] = 0;
            obs_b[d] = '0; last_len[d] = '0;
        end
    endtask

    task automatic observe(input int d, input logic dv, input logic [7:0] dq, input logic fs,
                           input logic fe, input logic [7:0] fl, input logic ferr, input logic serr);
        if (dv) begin
            if (n_out[d] < 3) obs_b[d][8*n_out[d] +: 8] = dq;
            n_out[d]++;
        end
        if (fs)   n_start[d]++;
        if (fe)   begin n_end[d]++; last_len[d] = fl; end
        if (ferr) n_ferr[d]++;
        if (serr) n_serr[d]++;
    endtask

    // drive one cycle, then look at registered outputs just after the edge
    task automatic step(input logic v, input logic b);
        din_valid = v;
        din = b;
        @(posedge clk);
        #1;
        observe(0, bus.dout_valid, bus.dout, bus.frame_start, bus.frame_end,
                bus.frame_len, bus.frame_error, bus.sync_error);
        observe(1, bus2.dout_valid, bus2.dout, bus2.frame_start, bus2.frame_end,
                bus2.frame_len, bus2.frame_error, bus2.sync_error);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) step(1'b1, b[i]);
    endtask

    function automatic logic [31:0] out_word0();
        return {11'd0, bus.dout, bus.dout_valid, bus.frame_start, bus.frame_end,
                bus.frame_len, bus.frame_error, bus.sync_error};
    endfunction

    vec_t vecs[7];

    initial begin
        vecs[0] = '{name:"clean",      sel:0, bits:{8'hFF,8'hA5,8'h12,8'h7E}, nbits:32,
                    exp_nout:3, exp_bytes:24'hFFA512, exp_start:1, exp_end:1, exp_len:8'd3, exp_ferr:0, exp_serr:0};
        vecs[1] = '{name:"bad_hdr",    sel:0, bits:{8'h00,8'h34,8'h12,8'h7F}, nbits:24,
                    exp_nout:0, exp_bytes:24'h0, exp_start:0, exp_end:0, exp_len:8'd0, exp_ferr:0, exp_serr:1};
        vecs[2] = '{name:"truncate",   sel:0, bits:{8'h00,8'h15,8'h3C,8'h7E}, nbits:21,
                    exp_nout:1, exp_bytes:24'h00003C, exp_start:1, exp_end:0, exp_len:8'd0, exp_ferr:1, exp_serr:0};
        vecs[3] = '{name:"hdr_only",   sel:0, bits:{24'h0,8'h7E}, nbits:8,
                    exp_nout:0, exp_bytes:24'h0, exp_start:0, exp_end:1, exp_len:8'd0, exp_ferr:0, exp_serr:0};
        vecs[4] = '{name:"hdr_trunc",  sel:0, bits:{24'h0,8'h7E}, nbits:4,
                    exp_nout:0, exp_bytes:24'h0, exp_start:0, exp_end:0, exp_len:8'd0, exp_ferr:1, exp_serr:0};
        vecs[5] = '{name:"overflow",   sel:1, bits:{8'h03,8'h02,8'h01,8'h7E}, nbits:32,
                    exp_nout:2, exp_bytes:24'h000201, exp_start:1, exp_end:0, exp_len:8'd0, exp_ferr:1, exp_serr:0};
        vecs[6] = '{name:"at_max_len", sel:1, bits:{8'h00,8'h0B,8'h0A,8'h7E}, nbits:24,
                    exp_nout:2, exp_bytes:24'h000B0A, exp_start:1, exp_end:1, exp_len:8'd2, exp_ferr:0, exp_serr:0};

        // reset state
        #12;
        chk("reset_outputs", out_word0(), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) begin
            int d;
            d = vecs[k].sel;
            clear_obs();
            for (int i = 0; i < vecs[k].nbits; i++) step(1'b1, vecs[k].bits[i]);
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
            chk({vecs[k].name, "_nout"},  32'(n_out[d]),   32'(vecs[k].exp_nout));
            chk({vecs[k].name, "_bytes"}, {8'd0, obs_b[d]}, {8'd0, vecs[k].exp_bytes});
            chk({vecs[k].name, "_start"}, 32'(n_start[d]), 32'(vecs[k].exp_start));
            chk({vecs[k].name, "_end"},   32'(n_end[d]),   32'(vecs[k].exp_end));
            chk({vecs[k].name, "_len"},   {24'd0, last_len[d]}, {24'd0, vecs[k].exp_len});
            chk({vecs[k].name, "_ferr"},  32'(n_ferr[d]),  32'(vecs[k].exp_ferr));
            chk({vecs[k].name, "_serr"},  32'(n_serr[d]),  32'(vecs[k].exp_serr));
        end

        // latency: strobe only after the edge that samples bit 7, frame_end on the gap cycle
        send_byte(8'h7E);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            b = 8'h12;
            step(1'b1, b[i]);
            chk("lat_dout_valid", {31'd0, bus.dout_valid}, {31'd0, (i == 7)});
        end
        chk("lat_dout", {24'd0, bus.dout}, 32'h12);
        chk("lat_start", {31'd0, bus.frame_start}, 32'd1);
        step(1'b0, 1'b0);
        chk("lat_end", {31'd0, bus.frame_end}, 32'd1);
        chk("lat_len", {24'd0, bus.frame_len}, 32'd1);
        step(1'b0, 1'b0);
        chk("lat_end_pulse", {31'd0, bus.frame_end}, 32'd0);
        chk("lat_len_held", {24'd0, bus.frame_len}, 32'd1);

        // back-to-back frames separated by a single idle cycle
        send_byte(8'h7E);
        send_byte(8'h01);
        step(1'b0, 1'b0);
        chk("b2b_a_end", {31'd0, bus.frame_end}, 32'd1);
        chk("b2b_a_len", {24'd0, bus.frame_len}, 32'd1);
        send_byte(8'h7E);
        chk("b2b_no_serr", {31'd0, bus.sync_error}, 32'd0);
        send_byte(8'h02);
        chk("b2b_b_start", {31'd0, bus.frame_start}, 32'd1);
        chk("b2b_b_dout0", {24'd0, bus.dout}, 32'h02);
        send_byte(8'h03);
        chk("b2b_b_start2", {31'd0, bus.frame_start}, 32'd0);
        chk("b2b_b_dout1", {24'd0, bus.dout}, 32'h03);
        step(1'b0, 1'b0);
        chk("b2b_b_end", {31'd0, bus.frame_end}, 32'd1);
        chk("b2b_b_len", {24'd0, bus.frame_len}, 32'd2);

        // asynchronous reset mid-payload clears held dout/frame_len at once
        send_byte(8'h7E);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_async", out_word0(), 32'd0);
        clear_obs();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("rst_mid_no_pulse", 32'(n_ferr[0] + n_serr[0] + n_end[0]), 32'd0);
        reset_n = 1'b1;
        clear_obs();
        send_byte(8'h7E);
        send_byte(8'h55);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("post_rst_nout", 32'(n_out[0]), 32'd1);
        chk("post_rst_byte", {8'd0, obs_b[0]}, 32'h55);
        chk("post_rst_end_len", {24'd0, last_len[0]}, 32'd1);
        chk("post_rst_errs", 32'(n_ferr[0] + n_serr[0]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/deframing.md
Name: deframing

Overview:
- Receive-side stage directly downstream of the serializer in the framing/encoding path.
- Consumes the serializer's bit stream (din / din_valid, LSB-first, 8 bits per byte, contiguous valid burst per frame) and reassembles bytes.
- Checks that the first byte of each burst is the sync header; delivers the payload bytes with frame start/end markers, frame length and error flags to the byte-level consumer.

Parameters:
- SYNC_BYTE, 8'h7E, required value of the first byte of every burst (the header).
- MAX_LEN, 255, maximum payload bytes per frame; range 1..255.

Ports:
- clk  input  1  clock, all state changes on rising edge
- reset_n  input  1  asynchronous active-low reset
- din  input  1  serial data bit, LSB of each byte first
- din_valid  input  1  din carries a bit this cycle; the high run forms one burst (frame)
- dout  output  8  reassembled payload byte
- dout_valid  output  1  one-cycle strobe: dout holds a payload byte
- frame_start  output  1  coincides with dout_valid of the first payload byte
- frame_end  output  1  one-cycle pulse: frame closed cleanly
- frame_len  output  8  payload byte count, valid while frame_end=1, held otherwise
- frame_error  output  1  one-cycle pulse: burst truncated mid-byte or exceeded MAX_LEN
- sync_error  output  1  one-cycle pulse: header byte != SYNC_BYTE

Behaviour:
- Reset: clk and reset_n are the only clock/reset; reset is asynchronous and active-low. While reset_n=0:
  - state=IDLE, bit counter=0, shift register=0, length counter=0.
  - dout=0, frame_len=0; dout_valid, frame_start, frame_end, frame_error and sync_error are all 0.
  - Asserting reset mid-frame abandons the frame silently, with no error pulse.
- Sampling: a bit is taken on each rising edge where din_valid=1. The shift register fills LSB-first, so bit k of the byte lands in position k. A 3-bit counter wraps 7 -> 0.
- Output timing: all outputs are registered, and every pulse lasts exactly one cycle.
  - dout, dout_valid and frame_start rise on the edge that samples bit 7, i.e. visible the cycle after bit 7 is presented.
  - frame_end, frame_error and frame_len update on the first edge where din_valid=0 after a burst.
- State machine:
  - IDLE: on din_valid=1, sample bit 0 and go to HEADER.
  - HEADER (collecting byte 0):
    - on bit 7, if the byte == SYNC_BYTE go to PAYLOAD, with no dout_valid for the header;
    - on bit 7, if the byte differs, pulse sync_error and go to DISCARD;
    - if din_valid drops before bit 7, pulse frame_error and go to IDLE.
  - PAYLOAD:
    - on each bit 7, pulse dout_valid and increment the length counter;
    - frame_start accompanies the first payload byte only;
    - if the increment would exceed MAX_LEN, do not emit the byte; pulse frame_error and go to DISCARD.
  - PAYLOAD, din_valid=0:
    - if counter=0 and length>=1, pulse frame_end with frame_len=length and go to IDLE;
    - if counter=0 and length=0 (header only), pulse frame_end with frame_len=0 and go to IDLE;
    - if counter!=0, pulse frame_error (partial byte dropped) and go to IDLE.
  - DISCARD: ignore bits until din_valid=0, then go to IDLE with no further pulse.
- Bursts: the minimum gap between bursts is one din_valid=0 cycle. That gap cycle both closes the old frame and returns to IDLE, so the next burst can start on the following cycle.
- Counters reset to 0 on every entry to IDLE.

Test Plan:
- Clean frame: burst with header 8'h7E then bytes 8'h12, 8'hA5, 8'hFF (32 valid cycles), then one idle cycle ->
  - dout_valid three times with 12, A5, FF, each one cycle after its bit 7;
  - frame_start on the 12 strobe;
  - frame_end with frame_len=3 one cycle after din_valid falls;
  - no error pulses.
- Bad header: first byte 8'h7F followed by 16 more bits -> sync_error once, one cycle after bit 7; no dout_valid; no frame_end; IDLE after din_valid falls.
- Truncation: header 7E, byte 8'h3C, then 5 bits of the next byte and din_valid falls -> one dout_valid (3C), then frame_error; no frame_end.
- Overflow with MAX_LEN=2: header plus 3 payload bytes -> two dout_valid strobes, frame_error on the third byte's bit 7, no frame_end.
- Back-to-back with one-cycle gap: frame A (7E, 01) then frame B (7E, 02, 03) -> frame_end with frame_len=1, then frame_start on 02, then frame_end with frame_len=2.
- Reset mid-payload (after 4 bits) -> all outputs 0 immediately; the next clean frame decodes correctly.
